car_position_controller: RTL

- Upstream stage of the car sprite renderer. Converts player buttons and a crash event into the registered car position `car_position_x[7:0]` (road-local) and `car_position_y[9:0]` (screen), plus a visibility flag.
- Updates only on the per-frame tick, so the sprite never tears mid-frame.
- Owns the IDLE / DRIVING / CRASHED / RESPAWN life cycle of the player car.

---
 rtl/car_position_controller_pkg.sv | 45 ++++
 rtl/car_speed_ramp.sv | 50 +++++
 rtl/car_position_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/car_position_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : car_position_controller_pkg
//  Description : Shared definitions for the player-car position controller:
//                life-cycle state encoding, screen/road geometry shared with
//                the sprite renderer, and the clamped single-axis step.
//  Revision    : 1.0 - initial release
// ============================================================================
package car_position_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVING = 2'd1,
        ST_CRASHED = 2'd2,
        ST_RESPAWN = 2'd3
    } car_state_t;

    // Geometry shared with the renderer
    localparam int ROAD_W   = 256;
    localparam int CAR_W    = 16;
    localparam int CAR_H    = 32;
    localparam int SCREEN_H = 480;

    // Move one axis by 'step' toward dec/inc, saturating at 0 and max_pos.
    // Opposing (or no) buttons leave the position untouched. Everything is
    // evaluated in 10 bits so the comparisons never wrap.
    function automatic logic [9:0] clamp_step(
        input logic [9:0] pos,
        input logic [9:0] step,
        input logic [9:0] max_pos,
        input logic       dec,
        input logic       inc
    );
        logic [9:0] res;
        res = pos;
        if (dec && !inc) begin
            res = (pos < step) ? 10'd0 : (pos - step);
        end else if (inc && !dec) begin
            res = (pos > (max_pos - step)) ? max_pos : (pos + step);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/car_speed_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : car_speed_ramp
//  Description : Acceleration for the player car. While any direction button
//                is held on a movement tick, speed rises by one every fourth
//                tick up to MAX_STEP; a tick with no button drops it to 1.
//  Ports       : clk, reset (async, active-high), clear (sync return to 1),
//                tick (qualified movement tick), any_btn, speed (current step)
//  Revision    : 1.0 - initial release
// ============================================================================
module car_speed_ramp #(
    parameter int MAX_STEP = 4,
    parameter int SPEED_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               tick,
    input  logic               any_btn,
    output logic [SPEED_W-1:0] speed
);

    logic [SPEED_W-1:0] r_speed;
    logic [1:0]         r_div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_speed <= SPEED_W'(1);
            r_div   <= 2'd0;
        end else if (clear) begin
            r_speed <= SPEED_W'(1);
            r_div   <= 2'd0;
        end else if (tick) begin
            if (any_btn) begin
                // Divider keeps counting after saturation; harmless.
                r_div <= r_div + 2'd1;
                if ((r_div == 2'd3) && (r_speed < SPEED_W'(MAX_STEP))) begin
                    r_speed <= r_speed + SPEED_W'(1);
                end
            end else begin
                r_speed <= SPEED_W'(1);
                r_div   <= 2'd0;
            end
        end
    end

    assign speed = r_speed;

endmodule
`default_nettype wire

// File: rtl/car_position_controller.sv
`default_nettype none
// ============================================================================
//  Module      : car_position_controller
//  Description : Turns player buttons and crash events into the registered
//                car position, updated only on the per-frame tick, and runs
//                the IDLE / DRIVING / CRASHED / RESPAWN life cycle.
//  Ports       : clk, reset (async, active-high), frame_tick, start,
//                btn_left/right/up/down, crash ->
//                car_position_x[7:0], car_position_y[9:0], car_visible, crashed
//  Config      : define CAR_ACCEL_EN to replace the fixed STEP with an
//                accelerating speed (car_speed_ramp, 1..MAX_STEP).
//  Revision    : 1.0 - initial release
// ============================================================================
module car_position_controller
    import car_position_controller_pkg::*;
#(
    parameter int X_START      = 120,
    parameter int Y_START      = 400,
    parameter int X_MAX        = ROAD_W - CAR_W - 1,
    parameter int Y_MAX        = SCREEN_H - CAR_H - 1,
    parameter int STEP         = 2,
    parameter int MAX_STEP     = 4,
    parameter int CRASH_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       crash,
    output logic [7:0] car_position_x,
    output logic [9:0] car_position_y,
    output logic       car_visible,
    output logic       crashed
);

    // Step width covers both the fixed and the accelerating step.
    localparam int c_STEP_W = $clog2(((STEP > MAX_STEP) ? STEP : MAX_STEP) + 1);
    // Counter needs at least bit 2 for the blink.
    localparam int c_CNT_W  = (CRASH_FRAMES > 8) ? $clog2(CRASH_FRAMES) : 3;

    car_state_t          r_state;
    car_state_t          w_state_next;
    logic [7:0]          r_x;
    logic [7:0]          w_x_next;
    logic [9:0]          r_y;
    logic [9:0]          w_y_next;
    logic [c_CNT_W-1:0]  r_crash_cnt;
    logic [c_CNT_W-1:0]  w_crash_cnt_next;
    logic [c_STEP_W-1:0] w_step;
    logic                w_move_tick;
    logic                w_respawn;

    // A crash on the tick cycle wins: no movement that frame.
    assign w_move_tick = frame_tick & (r_state == ST_DRIVING) & ~crash;
    assign w_respawn   = (r_state == ST_RESPAWN);

`ifdef CAR_ACCEL_EN
    logic w_any_btn;
    assign w_any_btn = btn_left | btn_right | btn_up | btn_down;

    car_speed_ramp #(
        .MAX_STEP (MAX_STEP),
        .SPEED_W  (c_STEP_W)
    ) u_speed_ramp (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_respawn),
        .tick     (w_move_tick),
        .any_btn  (w_any_btn),
        .speed    (w_step)
    );
`else
    assign w_step = c_STEP_W'(STEP);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_crash_cnt_next = r_crash_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_DRIVING;
                end
            end
            ST_DRIVING: begin
                if (crash) begin
                    w_state_next     = ST_CRASHED;
                    w_crash_cnt_next = '0;
                end else if (w_move_tick) begin
                    w_x_next = 8'(clamp_step(10'(r_x), 10'(w_step), 10'(X_MAX),
                                             btn_left, btn_right));
                    w_y_next = clamp_step(r_y, 10'(w_step), 10'(Y_MAX),
                                          btn_up, btn_down);
                end
            end
            ST_CRASHED: begin
                if (frame_tick) begin
                    w_crash_cnt_next = r_crash_cnt + 1'b1;
                    if (r_crash_cnt == c_CNT_W'(CRASH_FRAMES - 1)) begin
                        w_state_next = ST_RESPAWN;
                    end
                end
            end
            ST_RESPAWN: begin
                w_x_next     = 8'(X_START);
                w_y_next     = 10'(Y_START);
                w_state_next = ST_DRIVING;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_x         <= 8'(X_START);
            r_y         <= 10'(Y_START);
            r_crash_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_crash_cnt <= w_crash_cnt_next;
        end
    end

    assign car_position_x = r_x;
    assign car_position_y = r_y;
    assign crashed        = (r_state == ST_CRASHED);
    // Blink while crashed: hidden for counter values 4..7, 12..15, ...
    assign car_visible    = (r_state != ST_CRASHED) | ~r_crash_cnt[2];

endmodule
`default_nettype wire
